// File: rtl/hyperbus_rx_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_rx_burst_ctrl_if
// Description : Word stream between the DDR capture registers, the RX burst
//               sequencer and the source side of the read CDC FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface hyperbus_rx_burst_ctrl_if;
    logic [15:0] data_i;        // captured word from the DDR capture registers
    logic        fifo_ready_i;  // CDC FIFO source-side ready
    logic        valid_o;       // word valid towards the CDC FIFO
    logic [15:0] data_o;        // word towards the CDC FIFO
    logic        last_o;        // final word of the burst

    // Sequencer side: consumes captured words, produces the FIFO stream
    modport master (
        input  data_i,
        input  fifo_ready_i,
        output valid_o,
        output data_o,
        output last_o
    );

    // Environment side: capture registers and FIFO
    modport slave (
        output data_i,
        output fifo_ready_i,
        input  valid_o,
        input  data_o,
        input  last_o
    );
endinterface
`default_nettype wire

// File: rtl/hyperbus_rx_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_rx_burst_ctrl
// Description : RWDS-clocked read capture sequencer. Drops leading fill and
//               preamble words, forwards the configured number of words to
//               the CDC FIFO with a last tag, and flags FIFO overruns and
//               surplus RWDS edges.
// Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_rx_burst_ctrl #(
    parameter int BURST_W = 16,
    parameter int SKIP_W  = 4
) (
    input  wire logic               clk_rwds,
    input  wire logic               resetReadModule,
    input  wire logic [SKIP_W-1:0]  cfg_skip_words_i,
    input  wire logic [BURST_W-1:0] cfg_burst_len_i,
    hyperbus_rx_burst_ctrl_if.master bus,
    output logic                    done_o,
    output logic                    overflow_o,
    output logic                    extra_o,
    output logic [BURST_W-1:0]      word_cnt_o
);

    typedef enum logic [1:0] {
        ST_SKIP = 2'd0,
        ST_DATA = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [BURST_W-1:0] c_cnt_max = '1;

    state_t             state_q,    state_d;
    logic [SKIP_W-1:0]  skip_cnt_q, skip_cnt_d;
    logic [BURST_W-1:0] word_cnt_q, word_cnt_d;
    logic               valid_q,    valid_d;
    logic [15:0]        data_q,     data_d;
    logic               last_q,     last_d;
    logic               done_q,     done_d;
    logic               overflow_q, overflow_d;
    logic               extra_q,    extra_d;
    logic               w_take;

    // Next-state: decide per RWDS edge whether the captured word is dropped,
    // forwarded, or counted as a surplus edge after the burst completed
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        word_cnt_d = word_cnt_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        last_d     = 1'b0;
        done_d     = done_q;
        extra_d    = extra_q;
        w_take     = 1'b0;
        // The FIFO cannot stall RWDS: an unaccepted word is simply lost
        overflow_d = overflow_q | (valid_q & ~bus.fifo_ready_i);

        case (state_q)
            ST_SKIP: begin
                if (skip_cnt_q < cfg_skip_words_i) begin
                    skip_cnt_d = skip_cnt_q + 1'b1;
                end else begin
                    // Skip exhausted: this same edge already carries data
                    w_take = 1'b1;
                end
            end
            ST_DATA: begin
                w_take = 1'b1;
            end
            ST_DONE: begin
                extra_d = 1'b1;
            end
            default: begin
                state_d = ST_SKIP;
            end
        endcase

        if (w_take) begin
            valid_d = 1'b1;
            data_d  = bus.data_i;
            state_d = ST_DATA;
            if (word_cnt_q != c_cnt_max) begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
            // A zero burst length means unlimited streaming
            if ((cfg_burst_len_i != '0) && (word_cnt_d == cfg_burst_len_i)) begin
                last_d  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
        end
    end

    // State and registered outputs; reset clears everything for the next read
    always_ff @(posedge clk_rwds or posedge resetReadModule) begin
        if (resetReadModule) begin
            state_q    <= ST_SKIP;
            skip_cnt_q <= '0;
            word_cnt_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            extra_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            word_cnt_q <= word_cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            extra_q    <= extra_d;
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.last_o  = last_q;
    assign done_o      = done_q;
    assign overflow_o  = overflow_q;
    assign extra_o     = extra_q;
    assign word_cnt_o  = word_cnt_q;

endmodule
`default_nettype wire

// File: doc/hyperbus_rx_burst_ctrl.md
Name: hyperbus_rx_burst_ctrl

Overview:
Sequencer for the RWDS-clocked read capture path. It sits between the 8-to-16-bit DDR capture registers and the source side of the read CDC FIFO, all in the clk_rwds domain. It counts captured words per burst, drops leading pipeline-fill and preamble words, and forwards exactly the configured number of words with a last tag. It also flags FIFO overruns and surplus RWDS edges. It restarts on every assertion of resetReadModule, i.e. once per read transaction.

Parameters:
BURST_W, 16, width of burst-length configuration and word counter
SKIP_W, 4, width of skip-count configuration

Ports:
clk_rwds  input  1  delayed, gated RWDS capture clock (or test clock); one rising edge per captured 16-bit word
resetReadModule  input  1  asynchronous, active-high reset; asserted between read transactions
cfg_skip_words_i  input  SKIP_W  number of leading captured words to discard; quasi-static while reset is deasserted
cfg_burst_len_i  input  BURST_W  number of words to forward; 0 = unlimited streaming; quasi-static
data_i  input  16  word from DDR capture registers, sampled on clk_rwds rising edge
fifo_ready_i  input  1  CDC FIFO source-side ready
valid_o  output  1  registered word valid to CDC FIFO
data_o  output  16  registered word to CDC FIFO
last_o  output  1  marks the final word of the burst, aligned with valid_o
done_o  output  1  sticky; burst fully forwarded
overflow_o  output  1  sticky; FIFO not ready while valid_o was high
extra_o  output  1  sticky; RWDS edge received after done
word_cnt_o  output  BURST_W  number of words forwarded so far (saturating)

Behaviour:
- Reset: while resetReadModule=1, the following hold:
  - state=SKIP, skip_cnt=0, word_cnt_o=0
  - valid_o=0, data_o=0, last_o=0, done_o=0, overflow_o=0, extra_o=0
- Word index k = 0,1,2,… counts clk_rwds rising edges after reset release; each edge captures data_i as word k.
- States:
  - SKIP: if skip_cnt < cfg_skip_words_i, drop the word, skip_cnt++, valid_o←0. Otherwise treat the word exactly as in DATA on the same edge and move to DATA. No bubble; cfg_skip_words_i=0 forwards word 0.
  - DATA: valid_o←1, data_o←data_i, word_cnt_o++. If cfg_burst_len_i≠0 and the new count equals cfg_burst_len_i, then last_o←1, done_o←1, go to DONE; otherwise last_o←0.
  - DONE: valid_o←0, last_o←0; on each edge set extra_o←1. State is held until reset.
- Latency: word k appears on data_o/valid_o after the edge that captured it; it is sampled by the FIFO on the next edge. Throughput is 1 word per edge.
- No backpressure is possible because RWDS is memory-driven:
  - on an edge where valid_o=1 and fifo_ready_i=0, set overflow_o←1 (sticky);
  - the unaccepted word is lost, and data_o is overwritten with the next word.
- Unlimited mode (cfg_burst_len_i=0): the block never enters DONE and last_o stays 0.
- word_cnt_o saturates at 2^BURST_W−1 and never wraps; in unlimited mode forwarding continues after saturation.
- Configuration changes while reset is deasserted are undefined. The block samples cfg live; the integrator guarantees stability.
- Reset mid-burst: all state and sticky flags clear immediately and asynchronously; the next transaction starts at k=0.
- Reset release relative to clk_rwds: synchronization is the integrator's duty (RWDS gated off at release). The block makes no assumption beyond standard async-reset recovery.

Test Plan:
- skip=2, len=4, 8 edges with data 0x1000+k → valid_o high for words 0x1002..0x1005 only; last_o with 0x1005; done_o after 6th edge; extra_o set on edge 7; word_cnt_o=4.
- skip=0, len=1, single edge data 0xBEEF → valid_o=1, data_o=0xBEEF, last_o=1, done_o=1 after edge 1; next edge → valid_o=0, extra_o=1.
- skip=1, len=0, 20 edges → 19 words forwarded, last_o never set, done_o=0, word_cnt_o=19.
- skip=0, len=8, fifo_ready_i=0 on edge 4 only → overflow_o=1 from edge 4 and stays high; 8 words still presented; done_o=1.
- Reset asserted after 3 of 8 words, then a new transaction with skip=0, len=2 → all flags clear on assert; the new burst forwards 2 words with word_cnt_o=2; no stale last/done.
- BURST_W=4, len=0, 20 edges → word_cnt_o saturates at 15; valid_o remains high every edge.
